// File: rtl/upe_pkg.sv
// Shared widths and types for the uncertainty-propagation datapath.
package upe_pkg;
  localparam int UPE_W     = 16;
  localparam int UPE_OUT_W = 64;

  typedef logic [UPE_W-1:0]     upe_word_t;
  typedef logic [UPE_OUT_W-1:0] upe_result_t;
endpackage

// File: rtl/upe_umul.sv
// Registered unsigned WA x WB multiplier with a valid pass-through.
// The product register loads only on valid beats, so it holds its last result.
module upe_umul #(
  parameter int WA = 16,
  parameter int WB = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WA-1:0]    a,
  input  logic [WB-1:0]    b,
  output logic             out_valid,
  output logic [WA+WB-1:0] p
);
  logic [WA+WB-1:0] p_d, p_q;
  logic             valid_d, valid_q;

  always_comb begin
    p_d     = p_q;
    valid_d = in_valid;
    if (in_valid) begin
      p_d = {{WB{1'b0}}, a} * {{WA{1'b0}}, b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      p_q     <= p_d;
      valid_q <= valid_d;
    end
  end

  assign p         = p_q;
  assign out_valid = valid_q;
endmodule

// File: rtl/upe_triplemul16_uuu.sv
// Three-stage pipelined exact unsigned A*B*C, zero-extended to OUT_W bits.
// Stage 1: operand registers; stage 2: A*B with C delayed; stage 3: (A*B)*C.
module upe_triplemul16_uuu
  import upe_pkg::*;
#(
  parameter int W     = UPE_W,
  parameter int OUT_W = UPE_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [W-1:0]     C,
  output logic             out_valid,
  output logic [OUT_W-1:0] Out
);
  logic [W-1:0]   a_d, a_q, b_d, b_q, c_d, c_q;
  logic           v1_d, v1_q;
  logic [W-1:0]   c2_d, c2_q;
  logic [2*W-1:0] ab_p;
  logic           v2;
  logic [3*W-1:0] abc_p;

  always_comb begin
    a_d  = A;
    b_d  = B;
    c_d  = C;
    v1_d = in_valid;
    c2_d = c_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= '0;
      v1_q <= 1'b0;
      c2_q <= '0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      c_q  <= c_d;
      v1_q <= v1_d;
      c2_q <= c2_d;
    end
  end

  upe_umul #(.WA(W), .WB(W)) u_mul_ab (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v1_q),
    .a         (a_q),
    .b         (b_q),
    .out_valid (v2),
    .p         (ab_p)
  );

  // The final product register holds between valid beats, which gives Out its hold behaviour.
  upe_umul #(.WA(2*W), .WB(W)) u_mul_abc (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v2),
    .a         (ab_p),
    .b         (c2_q),
    .out_valid (out_valid),
    .p         (abc_p)
  );

  generate
    if (OUT_W > 3*W) begin : g_pad
      assign Out = {{(OUT_W-3*W){1'b0}}, abc_p};
    end else begin : g_nopad
      assign Out = abc_p;
    end
  endgenerate
endmodule

// File: tb/tb_upe_triplemul16_uuu.sv
// Directed and streaming checks for the three-operand unsigned multiplier.
module tb_upe_triplemul16_uuu;
  import upe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  upe_word_t   A = '0, B = '0, C = '0;
  logic        out_valid;
  upe_result_t Out;

  int errors = 0;
  int checks = 0;

  localparam int NB = 1003;
  upe_word_t   sa [NB];
  upe_word_t   sb [NB];
  upe_word_t   sc [NB];
  upe_result_t se [NB];

  upe_triplemul16_uuu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .C         (C),
    .out_valid (out_valid),
    .Out       (Out)
  );

  always #5 clk = ~clk;

  function automatic upe_result_t model(input upe_word_t a, input upe_word_t b, input upe_word_t c);
    return 64'(a) * 64'(b) * 64'(c);
  endfunction

  task automatic drive(input logic v, input upe_word_t a, input upe_word_t b, input upe_word_t c);
    @(negedge clk);
    in_valid = v;
    A = a;
    B = b;
    C = c;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    checks++;
    if (Out !== 64'h0) begin
      errors++;
      $display("FAIL reset_out: got %h want 0", Out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: out_valid=%b Out=%h", out_valid, Out);
  endtask

  // One isolated beat: valid must stay low for two edges, pulse on the third, then Out holds.
  task automatic test_single(input string name, input upe_word_t a, input upe_word_t b,
                             input upe_word_t c, input upe_result_t exp);
    drive(1'b1, a, b, c);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_lat1: out_valid got %b want 0", name, out_valid);
    end
    drive(1'b0, '0, '0, '0);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_lat2: out_valid got %b want 0", name, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || Out !== exp) begin
      errors++;
      $display("FAIL %s_result: got valid=%b Out=%h want valid=1 Out=%h", name, out_valid, Out, exp);
    end
    $display("%s: A=%h B=%h C=%h Out=%h", name, a, b, c, Out);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || Out !== exp) begin
      errors++;
      $display("FAIL %s_hold: got valid=%b Out=%h want valid=0 Out=%h", name, out_valid, Out, exp);
    end
  endtask

  task automatic test_corners();
    test_single("ones", 16'hFFFF, 16'hFFFF, 16'hFFFF, 64'h0000_FFFD_0002_FFFF);
    test_single("zero", 16'h0000, 16'hFFFF, 16'hFFFF, 64'h0);
    test_single("unit", 16'h0001, 16'h0001, 16'h0001, 64'h1);
  endtask

  task automatic test_back_to_back();
    sa[0] = 16'h3281; sb[0] = 16'h1E6D; sc[0] = 16'h1553; se[0] = 64'h0000_007F_FF3C_F7D7;
    sa[1] = 16'h1395; sb[1] = 16'h0529; sc[1] = 16'h0143; se[1] = 64'h0000_0000_7F7D_F7D7;
    sa[2] = 16'hFFFF; sb[2] = 16'hFFFF; sc[2] = 16'hFFFF; se[2] = 64'h0000_FFFD_0002_FFFF;
    for (int i = 3; i < NB; i++) begin
      sa[i] = 16'($urandom);
      sb[i] = 16'($urandom);
      sc[i] = 16'($urandom);
      se[i] = model(sa[i], sb[i], sc[i]);
    end
    for (int j = 0; j < NB + 2; j++) begin
      if (j < NB) drive(1'b1, sa[j], sb[j], sc[j]);
      else drive(1'b0, '0, '0, '0);
      @(posedge clk); #1;
      checks++;
      if (j < 2) begin
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL stream_fill%0d: out_valid got %b want 0", j, out_valid);
        end
      end else if (out_valid !== 1'b1 || Out !== se[j-2]) begin
        errors++;
        $display("FAIL stream_beat%0d: got valid=%b Out=%h want valid=1 Out=%h",
                 j - 2, out_valid, Out, se[j-2]);
      end else begin
        $display("stream beat %0d: A=%h B=%h C=%h Out=%h", j - 2, sa[j-2], sb[j-2], sc[j-2], Out);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 16'h1234, 16'h5678, 16'h9ABC);
    @(posedge clk);
    drive(1'b1, 16'h00FF, 16'h00FF, 16'h00FF);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || Out !== 64'h0) begin
      errors++;
      $display("FAIL midrst_async: got valid=%b Out=%h want valid=0 Out=0", out_valid, Out);
    end
    drive(1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || Out !== 64'h0) begin
        errors++;
        $display("FAIL midrst_flush%0d: got valid=%b Out=%h want valid=0 Out=0", k, out_valid, Out);
      end
    end
    $display("mid reset: in-flight beats discarded");
    test_single("after_rst", 16'h0002, 16'h0003, 16'h0005, 64'd30);
  endtask

  initial begin
    test_reset();
    test_single("vec1", 16'h3281, 16'h1E6D, 16'h1553, 64'h0000_007F_FF3C_F7D7);
    test_single("vec2", 16'h1395, 16'h0529, 16'h0143, 64'h0000_0000_7F7D_F7D7);
    test_corners();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
